register_file_scoreboard: RTL and testbench
===========================================

REGISTER_FILE_SCOREBOARD -- requirements
Module: register_file_scoreboard

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL provide parameter REG_COUNT, default 32, architectural registers (x0..x31); address width 5.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 write_back_enable  input  1  write-back port valid this cycle.
REQ-006 write_back_register  input  5  destination register from write-back stage.
REQ-007 write_back_value  input  DATA_WIDTH  value to commit.
REQ-008 rs1_addr, rs2_addr  input  5 each  decode read addresses.
REQ-009 rs1_data, rs2_data  output  DATA_WIDTH each  combinational read data.
REQ-010 issue_valid  input  1  decode requests issue of one instruction.
REQ-011 issue_rd  input  5  destination of issuing instruction (0 = none).
REQ-012 issue_uses_rs1, issue_uses_rs2  input  1 each  source operand actually read.
REQ-013 issue_stall  output  1  combinational; issue refused this cycle.
REQ-014 busy_count  output  6  registered count of pending (busy) registers.

Function
REQ-015 Write: on posedge with write_back_enable=1 and write_back_register!=0, SHALL store write_back_value; writes to x0 SHALL be discarded.
REQ-016 Reads of x0 SHALL return 0 regardless of any write.
REQ-017 Scoreboard: one busy bit per register x1..x31; x0 busy bit SHALL be constant 0.
REQ-018 issue_stall SHALL be 1 when issue_valid=1 and any of: (issue_uses_rs1 and rs1 busy), (issue_uses_rs2 and rs2 busy), (issue_rd!=0 and issue_rd busy, WAW).
REQ-019 Accepted issue (issue_valid=1, issue_stall=0, issue_rd!=0) SHALL set busy[issue_rd] at the posedge.
REQ-020 write_back_enable=1 with write_back_register!=0 SHALL clear busy[write_back_register] at the posedge.
REQ-021 Same-cycle accepted set and write-back clear on the same register: set SHALL win (bit ends 1).
REQ-022 Write-back to a non-busy register SHALL still write data and leave its busy bit 0.
REQ-023 busy_count SHALL equal the number of set busy bits after each posedge; range 0..31, no wrap.
REQ-024 issue_stall SHALL be 0 whenever issue_valid=0.

Reset
REQ-025 rst_n low SHALL immediately clear all registers to 0, all busy bits to 0, busy_count to 0, regardless of clk.
REQ-026 Reset mid-operation SHALL drop all pending busy state; first posedge after release SHALL behave as from empty.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN compiled in: read of a register being written this cycle (enable=1, address match, !=0) SHALL return write_back_value, and that register SHALL be treated as not busy for the REQ-018 source-operand checks; its WAW check is likewise waived.
REQ-028 Macro REGFILE_BYPASS_EN absent: reads SHALL return stored value only (new value visible the cycle after the write), and stall SHALL use the busy bits as stored.

Verification
REQ-029 Reset, write x5=0x0000_00AA, read rs1=x5 next cycle -> rs1_data=0x0000_00AA; write x0=0xFFFF_FFFF -> rs1_data for x0 reads 0.
REQ-030 Issue rd=x3 accepted -> busy_count=1; next cycle issue using rs1=x3 -> issue_stall=1; write-back x3 -> busy_count=0, stall drops.
REQ-031 With REGFILE_BYPASS_EN: same cycle as write-back x3=0x1234, rs1=x3 -> rs1_data=0x1234 and issue_stall=0; without macro -> issue_stall=1 that cycle, 0 next.
REQ-032 Busy x7; same cycle accepted issue rd=x7 is impossible (WAW stall=1); busy x8 and write-back x8 while issue rd=x8 under bypass -> busy[x8] remains 1, busy_count unchanged.
REQ-033 Issue 31 distinct rd x1..x31 -> busy_count=31; assert rst_n low between edges -> busy_count=0 and all reads 0 immediately.
REQ-034 Issue rd=x0 with issue_valid=1 -> issue_stall=0, busy_count stays 0.

Source files
------------

// File: rtl/register_file_scoreboard.sv
// Register file (x0 hard-wired to zero) with an issue scoreboard of per-register busy bits.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data and waive hazards on that register.
module register_file_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_back_enable,
    input  logic [4:0]            write_back_register,
    input  logic [DATA_WIDTH-1:0] write_back_value,
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_rd,
    input  logic                  issue_uses_rs1,
    input  logic                  issue_uses_rs2,
    output logic                  issue_stall,
    output logic [5:0]            busy_count
);

`ifdef REGFILE_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [REG_COUNT-1:0]  busy;
    logic [REG_COUNT-1:0]  busy_next;
    logic [REG_COUNT-1:0]  busy_eff;
    logic [REG_COUNT-1:0]  wb_hit;
    logic [5:0]            count_next;
    logic                  wb_we;
    logic                  issue_accept;

    assign wb_we = write_back_enable && (write_back_register != 5'd0);

    always_comb begin
        wb_hit = '0;
        if (wb_we) begin
            wb_hit[write_back_register] = 1'b1;
        end
    end

    // A register retiring this cycle is already resolved when its value is forwarded.
    assign busy_eff = BYPASS ? (busy & ~wb_hit) : busy;

    // Issue handshake: an instruction issues on the posedge where issue_valid=1 and
    // issue_stall=0; issue_stall is purely combinational and is 0 whenever issue_valid=0.
    assign issue_stall = issue_valid && (
                             (issue_uses_rs1 && busy_eff[rs1_addr]) ||
                             (issue_uses_rs2 && busy_eff[rs2_addr]) ||
                             ((issue_rd != 5'd0) && busy_eff[issue_rd]));

    assign issue_accept = issue_valid && !issue_stall && (issue_rd != 5'd0);

    // Clear first, then set, so a same-cycle issue on a retiring register keeps it busy.
    always_comb begin
        busy_next = busy & ~wb_hit;
        if (issue_accept) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_comb begin
        count_next = 6'd0;
        for (int i = 0; i < REG_COUNT; i++) begin
            count_next = count_next + {5'd0, busy_next[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
            busy       <= '0;
            busy_count <= 6'd0;
        end else begin
            if (wb_we) begin
                regs[write_back_register] <= write_back_value;
            end
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [4:0] addr);
        logic [DATA_WIDTH-1:0] val;
        if (addr == 5'd0) begin
            val = '0;
        end else if (BYPASS && wb_we && (write_back_register == addr)) begin
            val = write_back_value;
        end else begin
            val = regs[addr];
        end
        return val;
    endfunction

    assign rs1_data = read_port(rs1_addr);
    assign rs2_data = read_port(rs2_addr);

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Bench for register_file_scoreboard: directed hazard scenarios plus random traffic,
// checked by a monitor against an array-based model of the register file and busy set.
module tb_register_file_scoreboard;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int W = 1 + 32 + 32 + 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write_back_enable = 1'b0;
    logic [4:0]  write_back_register = '0;
    logic [31:0] write_back_value = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_uses_rs1 = 1'b0;
    logic        issue_uses_rs2 = 1'b0;
    logic        issue_stall;
    logic [5:0]  busy_count;

    register_file_scoreboard dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .write_back_enable   (write_back_enable),
        .write_back_register (write_back_register),
        .write_back_value    (write_back_value),
        .rs1_addr            (rs1_addr),
        .rs2_addr            (rs2_addr),
        .rs1_data            (rs1_data),
        .rs2_data            (rs2_data),
        .issue_valid         (issue_valid),
        .issue_rd            (issue_rd),
        .issue_uses_rs1      (issue_uses_rs1),
        .issue_uses_rs2      (issue_uses_rs2),
        .issue_stall         (issue_stall),
        .busy_count          (busy_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic bit wb_active();
        return write_back_enable && (write_back_register != 5'd0);
    endfunction

    function automatic bit src_busy(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (BYP && wb_active() && write_back_register == r) return 1'b0;
        return m_busy[r];
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (BYP && wb_active() && write_back_register == a) return write_back_value;
        return m_regs[a];
    endfunction

    function automatic bit m_stall();
        if (!issue_valid) return 1'b0;
        return (issue_uses_rs1 && src_busy(rs1_addr)) ||
               (issue_uses_rs2 && src_busy(rs2_addr)) ||
               src_busy(issue_rd);
    endfunction

    function automatic logic [5:0] m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return 6'(c);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Push what the DUT must show this cycle, then advance the model past the next posedge.
    task automatic push_and_step(input bit in_reset);
        bit st;
        st = m_stall();
        exp_q.push_back({st, m_read(rs1_addr), m_read(rs2_addr), m_count()});
        if (!in_reset) begin
            if (wb_active()) begin
                m_regs[write_back_register] = write_back_value;
                m_busy[write_back_register] = 1'b0;
            end
            if (issue_valid && !st && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
        end
    endtask

    // driver tasks
    task automatic drive(input bit iv, input logic [4:0] rd, input bit u1, input bit u2,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input bit we, input logic [4:0] wr, input logic [31:0] wv);
        @(posedge clk);
        #1;
        issue_valid = iv; issue_rd = rd; issue_uses_rs1 = u1; issue_uses_rs2 = u2;
        rs1_addr = a1; rs2_addr = a2;
        write_back_enable = we; write_back_register = wr; write_back_value = wv;
        push_and_step(1'b0);
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        drive(1'b0, 5'd0, 1'b0, 1'b0, a1, a2, 1'b0, 5'd0, 32'd0);
    endtask

    // Reset asserted between edges; the monitor checks outputs before any posedge follows.
    task automatic do_reset(input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        issue_valid = 1'b0; issue_rd = 5'd0; issue_uses_rs1 = 1'b0; issue_uses_rs2 = 1'b0;
        write_back_enable = 1'b0; write_back_register = 5'd0; write_back_value = '0;
        rs1_addr = a1; rs2_addr = a2;
        model_clear();
        push_and_step(1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks += 4;
            if (issue_stall !== e[70]) begin
                n_fail++;
                $display("FAIL issue_stall t=%0t got %b want %b", $time, issue_stall, e[70]);
            end
            if (rs1_data !== e[69:38]) begin
                n_fail++;
                $display("FAIL rs1_data t=%0t x%0d got %h want %h", $time, rs1_addr, rs1_data, e[69:38]);
            end
            if (rs2_data !== e[37:6]) begin
                n_fail++;
                $display("FAIL rs2_data t=%0t x%0d got %h want %h", $time, rs2_addr, rs2_data, e[37:6]);
            end
            if (busy_count !== e[5:0]) begin
                n_fail++;
                $display("FAIL busy_count t=%0t got %0d want %0d", $time, busy_count, e[5:0]);
            end
        end
    end

    initial begin
        model_clear();
        #12;
        rst_n = 1'b1;

        // reset state, basic write/read, x0 discard
        idle(5'd5, 5'd0);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 1'b1, 5'd5, 32'h0000_00AA);
        idle(5'd5, 5'd0);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 32'hFFFF_FFFF);
        idle(5'd0, 5'd5);

        // RAW on x3, resolved by write-back
        drive(1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        drive(1'b1, 5'd0, 1'b1, 1'b0, 5'd3, 5'd0, 1'b0, 5'd0, 32'd0);
        drive(1'b1, 5'd0, 1'b1, 1'b0, 5'd3, 5'd3, 1'b1, 5'd3, 32'h0000_1234);
        drive(1'b1, 5'd0, 1'b1, 1'b0, 5'd3, 5'd0, 1'b0, 5'd0, 32'd0);

        // WAW on x7, set-wins on x8
        drive(1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        drive(1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        drive(1'b1, 5'd8, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        drive(1'b1, 5'd8, 1'b0, 1'b1, 5'd0, 5'd8, 1'b1, 5'd8, 32'hCAFE_0008);
        idle(5'd8, 5'd7);

        // write-back to a register that is not busy
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd0, 1'b1, 5'd9, 32'h0000_0099);
        idle(5'd9, 5'd0);

        // issue with rd=x0
        do_reset(5'd0, 5'd0);
        drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        idle(5'd0, 5'd0);

        // fill every busy bit, then asynchronous reset
        for (int r = 1; r < 32; r++) begin
            drive(1'b1, 5'(r), 1'b0, 1'b0, 5'(r), 5'd0, 1'b1, 5'(r), 32'h100 + 32'(r));
        end
        idle(5'd5, 5'd31);
        drive(1'b1, 5'd4, 1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0);
        do_reset(5'd5, 5'd31);
        drive(1'b1, 5'd4, 1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0);
        idle(5'd4, 5'd1);

        // random traffic concentrated on a few registers to provoke hazards
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            end else begin
                drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)),
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), $urandom);
            end
        end
        idle(5'd1, 5'd2);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain queue left %0d want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
